vga_st_overlay_mixer: RTL and testbench

Parametrised N-layer Avalon-ST pixel compositor that merges a background video stream (camera frames from the SDRAM read buffer) with up to LAYERS-1 overlay streams (e.g. SSRAM-backed graphics) into one stream for the VGA stream composer. It supersedes the fixed two-source overlay path:

- arbitrary layer count and pixel width;
- per-layer colour-key transparency with frame-latched controls;
- automatic start-of-frame realignment when sources slip.

It sits entirely in the qsys clock domain between the read buffers and the VGA composer.

---
 rtl/vga_st_overlay_mixer_if.sv | 27 ++
 rtl/vga_st_overlay_mixer.sv | 104 ++++++++++
 tb/tb_vga_st_overlay_mixer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_st_overlay_mixer_if.sv
// Avalon-ST bundle for the overlay mixer: LAYERS packed input streams plus one composited output stream.
// slave is the mixer's view, master is the view of the surrounding sources and sink.
interface vga_st_overlay_mixer_if #(
  parameter int LAYERS = 2,
  parameter int PIX_W  = 24
);
  logic [LAYERS*PIX_W-1:0] s_data;
  logic [LAYERS-1:0]       s_valid;
  logic [LAYERS-1:0]       s_sop;
  logic [LAYERS-1:0]       s_eop;
  logic [LAYERS-1:0]       s_ready;
  logic [PIX_W-1:0]        m_data;
  logic                    m_valid;
  logic                    m_sop;
  logic                    m_eop;
  logic                    m_ready;

  modport slave (
    input  s_data, s_valid, s_sop, s_eop, m_ready,
    output s_ready, m_data, m_valid, m_sop, m_eop
  );

  modport master (
    output s_data, s_valid, s_sop, s_eop, m_ready,
    input  s_ready, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/vga_st_overlay_mixer.sv
// N-layer Avalon-ST pixel compositor with colour-key transparency, frame-latched controls
// and automatic start-of-frame realignment of the input streams.
module vga_st_overlay_mixer #(
  parameter int                LAYERS   = 2,
  parameter int                PIX_W    = 24,
  parameter logic [PIX_W-1:0]  BG_COLOR = 24'h000000,
  parameter int                ERR_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vga_st_overlay_mixer_if.slave   st,
  input  logic [LAYERS-1:0]       layer_en,
  input  logic [LAYERS-1:0]       key_en,
  input  logic [LAYERS*PIX_W-1:0] key_color,
  output logic [ERR_W-1:0]        err_count,
  output logic                    aligned
);

  typedef enum logic {ALIGN, RUN} state_t;

  state_t                  state;
  logic [LAYERS-1:0]       en_sh;
  logic [LAYERS-1:0]       key_en_sh;
  logic [LAYERS*PIX_W-1:0] key_sh;

  logic                    out_free;
  logic                    fire;
  logic                    mismatch;
  logic                    all_sop;
  logic                    capture;
  logic [LAYERS-1:0]       en_eff;
  logic [LAYERS-1:0]       key_en_eff;
  logic [LAYERS*PIX_W-1:0] key_eff;
  logic [PIX_W-1:0]        pix;

  // A sop beat that fires cleanly sees the fresh controls; every other beat uses the frame shadows.
  always_comb begin
    out_free   = !st.m_valid || st.m_ready;
    fire       = (state == RUN) && (&st.s_valid) && out_free;
    mismatch   = (st.s_sop != {LAYERS{st.s_sop[0]}}) || (st.s_eop != {LAYERS{st.s_eop[0]}});
    all_sop    = &(st.s_valid & st.s_sop);
    capture    = fire && !mismatch && st.s_sop[0];
    en_eff     = capture ? layer_en  : en_sh;
    key_en_eff = capture ? key_en    : key_en_sh;
    key_eff    = capture ? key_color : key_sh;
    pix        = BG_COLOR;
    for (int i = 0; i < LAYERS; i++) begin
      if (en_eff[i] && !(key_en_eff[i] &&
          st.s_data[i*PIX_W +: PIX_W] == key_eff[i*PIX_W +: PIX_W])) begin
        pix = st.s_data[i*PIX_W +: PIX_W];
      end
    end
  end

  // While aligning, non-sop heads are drained so every layer ends up parked on a sop.
  always_comb begin
    st.s_ready = '0;
    if (reset_n) begin
      if (state == ALIGN) st.s_ready = st.s_valid & ~st.s_sop;
      else                st.s_ready = {LAYERS{fire}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ALIGN;
      st.m_valid <= 1'b0;
      st.m_data  <= '0;
      st.m_sop   <= 1'b0;
      st.m_eop   <= 1'b0;
      err_count  <= '0;
      en_sh      <= '0;
      key_en_sh  <= '0;
      key_sh     <= '0;
    end else begin
      if (fire && !mismatch) begin
        st.m_valid <= 1'b1;
        st.m_data  <= pix;
        st.m_sop   <= st.s_sop[0];
        st.m_eop   <= st.s_eop[0];
      end else if (st.m_ready) begin
        st.m_valid <= 1'b0;
      end
      if (capture) begin
        en_sh     <= layer_en;
        key_en_sh <= key_en;
        key_sh    <= key_color;
      end
      case (state)
        ALIGN: if (all_sop) state <= RUN;
        RUN: begin
          if (fire && mismatch) begin
            state <= ALIGN;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
          end
        end
        default: state <= ALIGN;
      endcase
    end
  end

  assign aligned = (state == RUN);

endmodule

// File: tb/tb_vga_st_overlay_mixer.sv
// Randomised scoreboard bench for vga_st_overlay_mixer (2 layers, 2-bit error counter)
// against a transaction-level reference model of the alignment and compositing rules.
module tb_vga_st_overlay_mixer;
  localparam logic [23:0] BG      = 24'h102030;
  localparam int          ERR_MAX = 3;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  en;
    logic [1:0]  ken;
    logic [47:0] kcol;
  } beat_t;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  layer_en;
  logic [1:0]  key_en;
  logic [47:0] key_color;
  logic [1:0]  err_count;
  logic        aligned;

  vga_st_overlay_mixer_if #(.LAYERS(2), .PIX_W(24)) bus ();

  vga_st_overlay_mixer #(.LAYERS(2), .PIX_W(24), .BG_COLOR(BG), .ERR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .st(bus), .layer_en(layer_en), .key_en(key_en),
    .key_color(key_color), .err_count(err_count), .aligned(aligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t q0[$], q1[$], m0[$], m1[$];
  out_t  exp_q[$];
  int    n_cmp = 0, n_err = 0;
  bit    drv_on = 0;
  int    gap_pct = 0, ready_pct = 100;
  logic [1:0]  cur_en = '0, cur_ken = '0;
  logic [47:0] cur_kcol = '0;
  bit          mdl_run = 0;
  int          mdl_err = 0;
  logic [1:0]  sh_en = '0, sh_ken = '0;
  logic [47:0] sh_kcol = '0;
  bit lat_arm = 0, lat_watch = 0;
  int fire_cyc = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_beat(input int layer, input logic [23:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.en = cur_en; b.ken = cur_ken; b.kcol = cur_kcol;
    if (layer == 0) begin q0.push_back(b); m0.push_back(b); end
    else begin q1.push_back(b); m1.push_back(b); end
  endtask

  task automatic push_frame(input int layer, input int len, input logic [23:0] base);
    for (int k = 0; k < len; k++) push_beat(layer, base + 24'(k), k == 0, k == len - 1);
  endtask

  // Reference model: whole-beat view of drain-to-sop, lockstep consumption and top-down layer pick.
  task automatic run_model();
    beat_t b0, b1;
    logic [23:0] px, d;
    bit found;
    forever begin
      if (!mdl_run) begin
        while (m0.size() > 0 && !m0[0].sop) void'(m0.pop_front());
        while (m1.size() > 0 && !m1[0].sop) void'(m1.pop_front());
        if (m0.size() == 0 || m1.size() == 0) break;
        mdl_run = 1;
      end else begin
        if (m0.size() == 0 || m1.size() == 0) break;
        b0 = m0.pop_front();
        b1 = m1.pop_front();
        if (b0.sop != b1.sop || b0.eop != b1.eop) begin
          if (mdl_err < ERR_MAX) mdl_err++;
          mdl_run = 0;
        end else begin
          if (b0.sop) begin sh_en = b0.en; sh_ken = b0.ken; sh_kcol = b0.kcol; end
          px = BG;
          found = 0;
          for (int i = 1; i >= 0 && !found; i--) begin
            d = (i == 1) ? b1.data : b0.data;
            if (sh_en[i] && !(sh_ken[i] && d == sh_kcol[i*24 +: 24])) begin
              px = d;
              found = 1;
            end
          end
          exp_q.push_back('{data: px, sop: b0.sop, eop: b0.eop});
        end
      end
    end
  endtask

  task automatic apply_stimulus(input int gap, input int rdy);
    gap_pct = gap;
    ready_pct = rdy;
    run_model();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || bus.m_valid) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check_output({name, "_drained"}, 64'(n < 20000), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check_output({name, "_err_count"}, 64'(err_count), 64'(mdl_err));
    check_output({name, "_aligned"}, 64'(aligned), 64'(mdl_run));
  endtask

  function automatic logic [23:0] rand_pix();
    case ($urandom_range(3))
      0:       return 24'hFF00FF;
      1:       return 24'h00FF00;
      default: return 24'($urandom);
    endcase
  endfunction

  // Source and sink driver: presents queue heads at negedge and pops what the DUT accepted.
  initial begin
    logic [1:0] v, rdy;
    forever begin
      @(negedge clk);
      if (drv_on) begin
        v[0] = q0.size() > 0 && $urandom_range(99) >= gap_pct;
        v[1] = q1.size() > 0 && $urandom_range(99) >= gap_pct;
        bus.s_valid = v;
        bus.s_data  = {q1.size() > 0 ? q1[0].data : 24'h0, q0.size() > 0 ? q0[0].data : 24'h0};
        bus.s_sop   = {q1.size() > 0 ? q1[0].sop : 1'b0, q0.size() > 0 ? q0[0].sop : 1'b0};
        bus.s_eop   = {q1.size() > 0 ? q1[0].eop : 1'b0, q0.size() > 0 ? q0[0].eop : 1'b0};
        if (q0.size() > 0) begin
          layer_en = q0[0].en; key_en = q0[0].ken; key_color = q0[0].kcol;
        end
        bus.m_ready = $urandom_range(99) < ready_pct;
        #4;
        rdy = bus.s_ready;
        if (bus.m_valid && !bus.m_ready) check_output("stall_s_ready", 64'(rdy), 64'(0));
        if (v[0] && rdy[0]) void'(q0.pop_front());
        if (v[1] && rdy[1]) void'(q1.pop_front());
        if (lat_arm && rdy == 2'b11) begin
          fire_cyc = cyc;
          lat_arm = 0;
          lat_watch = 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted output beat and checks stall stability.
  initial begin
    out_t e;
    bit was_stall = 0;
    logic [25:0] held = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
        if (was_stall) check_output("stall_hold", 64'({bus.m_data, bus.m_sop, bus.m_eop}), 64'(held));
        if (lat_watch && bus.m_valid) begin
          check_output("first_valid_latency", 64'(cyc - fire_cyc), 64'(1));
          lat_watch = 0;
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_beat", 64'(bus.m_data), 64'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check_output("beat", 64'({bus.m_data, bus.m_sop, bus.m_eop}), 64'({e.data, e.sop, e.eop}));
          end
        end
        was_stall = bus.m_valid && !bus.m_ready;
        held = {bus.m_data, bus.m_sop, bus.m_eop};
      end else begin
        was_stall = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    int len;
    reset_n = 1'b0;
    layer_en = '0; key_en = '0; key_color = '0;
    bus.s_valid = 2'b11; bus.s_sop = 2'b00; bus.s_eop = 2'b00; bus.s_data = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check_output("rst_m_data", 64'(bus.m_data), 64'(0));
    check_output("rst_m_sop_eop", 64'({bus.m_sop, bus.m_eop}), 64'(0));
    check_output("rst_s_ready", 64'(bus.s_ready), 64'(0));
    check_output("rst_err_count", 64'(err_count), 64'(0));
    check_output("rst_aligned", 64'(aligned), 64'(0));
    @(negedge clk);
    bus.s_valid = 2'b00;
    reset_n = 1'b1;
    drv_on = 1;
    @(posedge clk); #1;

    // Layer 1 starts three beats late, then an early eop on layer 1 breaks alignment.
    cur_en = 2'b01;
    push_frame(0, 4, 24'h000A00);
    push_beat(1, 24'h0B0001, 0, 0); push_beat(1, 24'h0B0002, 0, 0); push_beat(1, 24'h0B0003, 0, 1);
    push_frame(1, 4, 24'h000B00);
    apply_stimulus(0, 100);
    wait_drain("late_layer1");
    push_frame(0, 4, 24'h000C00);
    push_beat(1, 24'h0D0000, 1, 0); push_beat(1, 24'h0D0001, 0, 1);
    push_beat(1, 24'h0D0002, 0, 0); push_beat(1, 24'h0D0003, 0, 1);
    apply_stimulus(0, 100);
    wait_drain("early_eop");

    // Two aligned 4-pixel frames, only layer 0 visible; also checks first-beat latency.
    lat_arm = 1;
    push_frame(0, 4, 24'h000001); push_frame(0, 4, 24'h000011);
    push_frame(1, 4, 24'h777700); push_frame(1, 4, 24'h777710);
    apply_stimulus(0, 100);
    wait_drain("two_frames");

    // Colour key on layer 1.
    cur_en = 2'b11; cur_ken = 2'b10; cur_kcol = {24'hFF00FF, 24'h000000};
    push_frame(0, 4, 24'h000001);
    push_beat(1, 24'hFF00FF, 1, 0); push_beat(1, 24'h123456, 0, 0);
    push_beat(1, 24'hFF00FF, 0, 0); push_beat(1, 24'hABCDEF, 0, 1);
    apply_stimulus(0, 100);
    wait_drain("color_key");

    // Mid-frame enable change only takes effect at the next frame.
    cur_en = 2'b00; cur_ken = 2'b00; cur_kcol = '0;
    push_beat(0, 24'h000101, 1, 0); push_beat(0, 24'h000102, 0, 0);
    cur_en = 2'b01;
    push_beat(0, 24'h000103, 0, 0); push_beat(0, 24'h000104, 0, 1);
    push_frame(0, 4, 24'h000201);
    push_frame(1, 4, 24'h555500); push_frame(1, 4, 24'h555510);
    apply_stimulus(0, 100);
    wait_drain("mid_frame_enable");

    // Random traffic with valid gaps, back-pressure and mid-frame control churn.
    total = 0;
    while (total < 1000) begin
      len = $urandom_range(1, 12);
      cur_en = 2'($urandom_range(3)); cur_ken = 2'($urandom_range(3));
      cur_kcol = {($urandom_range(1) == 1) ? 24'hFF00FF : 24'h00FF00,
                  ($urandom_range(1) == 1) ? 24'hFF00FF : 24'h00FF00};
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(4) == 0) cur_en = 2'($urandom_range(3));
        push_beat(0, rand_pix(), k == 0, k == len - 1);
        push_beat(1, rand_pix(), k == 0, k == len - 1);
      end
      total += len;
    end
    apply_stimulus(30, 50);
    wait_drain("random");

    // Repeated early-eop frames drive the 2-bit error counter into saturation.
    for (int n = 0; n < 4; n++) begin
      cur_en = 2'b11;
      push_frame(0, 4, 24'h00E000 + 24'(n * 16));
      push_beat(1, 24'h0E0000, 1, 0); push_beat(1, 24'h0E0001, 0, 1);
      push_beat(1, 24'h0E0002, 0, 0); push_beat(1, 24'h0E0003, 0, 1);
    end
    apply_stimulus(10, 70);
    wait_drain("err_saturate");
    check_output("err_saturated", 64'(err_count), 64'(ERR_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
